sa_operand_feeder: RTL and testbench
====================================

Name: sa_operand_feeder

Overview:
- Transmit side of the systolic-array operand interface.
- Accepts one K-beat operand stream per job: each beat is one column of A (N values) and one row of B (N values), using a valid/ready handshake.
- Skews the beats onto the array's west edge (a_edge, row i delayed i cycles) and north edge (b_edge, column j delayed j cycles).
- Issues a broadcast accumulator clear, then drains the array and pulses done once every PE accumulator holds its final dot product.

Parameters:
- N, 4, array dimension (N rows x N columns of PEs).
- A_W, 8, signed A operand width.
- B_W, 8, signed B operand width.
- K_MAX, 256, maximum beats per job; KW = $clog2(K_MAX+1).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low (rst=0 resets).
- start  input  1  begin a job; sampled only in IDLE.
- k_len  input  KW  beats in the job; sampled with start; values above K_MAX are not allowed.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse: all accumulators final.
- in_valid  input  1  beat offered.
- in_ready  output  1  feeder accepts a beat.
- a_vec  input  N*A_W  A column; slice i feeds row i.
- b_vec  input  N*B_W  B row; slice j feeds column j.
- a_edge  output  N*A_W  west-edge operands; slice i goes to PE(i,0) a_in.
- b_edge  output  N*B_W  north-edge operands; slice j goes to PE(0,j) b_in.
- clr_out  output  1  broadcast accumulator clear to every PE clr.

Behaviour:
- Reset (rst=0 at a clock edge), including mid-job:
  - state goes to IDLE; all delay-line stages and both counters go to 0.
  - a_edge=0, b_edge=0, clr_out=0, busy=0, done=0, in_ready=0.
- States:
  - IDLE: start=1 -> latch k_len, go to CLEAR.
  - CLEAR: one cycle; clr_out=1; edges carry zeros. Next state is STREAM, or DRAIN if k_len==0.
  - STREAM: in_ready=1. Each accepted beat (in_valid & in_ready) increments beat_cnt. The cycle the beat_cnt-th accept equals k_len, go to DRAIN and load drain_cnt.
  - DRAIN: in_ready=0, zeros injected. Leave when drain_cnt expires; done=1 in the first IDLE cycle after DRAIN.
- Outputs by state: clr_out is high only in CLEAR. in_ready is high only in STREAM (it is a registered-state decode, with no combinational dependence on in_valid).
- start is ignored while busy. in_valid is ignored outside STREAM.
- Skew datapath:
  - Accepted beat slices are registered into stage 0. Row i / column j pass through i / j further register stages, so latency from the accept edge to a_edge[i] is 1+i cycles, and to b_edge[j] is 1+j cycles.
  - Any cycle without an accept injects zero into stage 0.
  - Bubbles are harmless: a beat's a and b parts still meet at PE(i,j) in the same cycle (accept + 1 + i + j), and zero products add nothing.
  - The delay lines keep shifting in every state.
- Done timing:
  - Last accept at cycle t; its operands reach PE(N-1,N-1) inputs at cycle t+2N-1, and that accumulator updates at the following edge.
  - done is asserted exactly at cycle t+2N (counting t as cycle 0), so DRAIN lasts 2N-1 cycles.
  - k_len==0: DRAIN lasts one cycle; done is asserted 3 cycles after start was accepted.
- Clear safety: the previous job fully drained before done, so the CLEAR cycle always sees zeros in flight. PEs do not accumulate in their clr cycle, and in that cycle they receive only zeros.
- The feeder does no arithmetic. Accumulator width and overflow are the PE's concern.

Test Plan:
- Reset: hold rst=0 two cycles with in_valid=1 and start=1 -> a_edge=b_edge=0, busy=done=clr_out=in_ready=0.
- N=2 matmul, k_len=2: A=[[1,2],[3,4]], B=[[5,6],[7,8]]; beats (a=(1,3), b=(5,6)) then (a=(2,4), b=(7,8)), back-to-back.
  - Edge timing: a_edge row1 lags row0 by exactly one cycle.
  - done 4 cycles after the second accept.
  - Attached PE array holds C=[[19,22],[43,50]].
- Same job with in_valid low for 3 cycles between beats -> identical C; done 4 cycles after the second accept; in_ready stays 1 throughout STREAM.
- Signed extremes, N=2, k_len=4, every operand -128 -> every accumulator 65536. A second job follows with all operands 1 -> every accumulator 4, proving the CLEAR took effect.
- k_len=0 -> clr_out high for one cycle, in_ready never high, done asserted 3 cycles after start.
- Mid-job control:
  - start pulsed during STREAM -> ignored; k_len unchanged.
  - rst=0 mid-STREAM -> all outputs 0 next cycle, state IDLE.
  - After release, a new job completes correctly.

Source files
------------

// File: rtl/sa_operand_feeder.sv
// rtl/sa_operand_feeder.sv - systolic-array operand feeder: skews A/B beats onto the array edges
module sa_operand_feeder #(
  parameter int N     = 4,
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int K_MAX = 256,
  parameter int KW    = $clog2(K_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [KW-1:0]      k_len,
  output logic               busy,
  output logic               done,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*A_W-1:0]   a_vec,
  input  logic [N*B_W-1:0]   b_vec,
  output logic [N*A_W-1:0]   a_edge,
  output logic [N*B_W-1:0]   b_edge,
  output logic               clr_out
);

  localparam int DW = (2 * N > 1) ? $clog2(2 * N) : 1;
  // Last beat needs 2N-1 further cycles to reach and update PE(N-1,N-1).
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(2 * N - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [KW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
  logic            done_q, done_d;
  logic            take;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    done_d      = 1'b0;
    take        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d        = k_len;
          beat_cnt_d = '0;
          state_d    = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (k_q == '0) begin
          drain_cnt_d = '0;
          state_d     = S_DRAIN;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (in_valid) begin
          take       = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_d == k_q) begin
            drain_cnt_d = DRAIN_LOAD;
            state_d     = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      done_q      <= done_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign in_ready = (state_q == S_STREAM);
  assign clr_out  = (state_q == S_CLEAR);
  assign done     = done_q;

  // Lane g gets 1+g register stages; non-accept cycles inject zero bubbles.
  for (genvar g = 0; g < N; g++) begin : g_a_lane
    logic [A_W-1:0] dl_q [0:g];
    logic [A_W-1:0] dl_d [0:g];

    always_comb begin
      dl_d[0] = take ? a_vec[g*A_W +: A_W] : '0;
      for (int s = 1; s <= g; s++) dl_d[s] = dl_q[s-1];
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int s = 0; s <= g; s++) dl_q[s] <= '0;
      end else begin
        for (int s = 0; s <= g; s++) dl_q[s] <= dl_d[s];
      end
    end

    assign a_edge[g*A_W +: A_W] = dl_q[g];
  end

  for (genvar g = 0; g < N; g++) begin : g_b_lane
    logic [B_W-1:0] dl_q [0:g];
    logic [B_W-1:0] dl_d [0:g];

    always_comb begin
      dl_d[0] = take ? b_vec[g*B_W +: B_W] : '0;
      for (int s = 1; s <= g; s++) dl_d[s] = dl_q[s-1];
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int s = 0; s <= g; s++) dl_q[s] <= '0;
      end else begin
        for (int s = 0; s <= g; s++) dl_q[s] <= dl_d[s];
      end
    end

    assign b_edge[g*B_W +: B_W] = dl_q[g];
  end

endmodule

// File: tb/tb_sa_operand_feeder.sv
// tb/tb_sa_operand_feeder.sv - scoreboard bench for sa_operand_feeder driving a 2x2 PE array model
module tb_sa_operand_feeder;
  localparam int N     = 2;
  localparam int A_W   = 8;
  localparam int B_W   = 8;
  localparam int K_MAX = 256;
  localparam int KW    = $clog2(K_MAX + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [KW-1:0]    k_len = '0;
  logic             busy, done, in_ready, clr_out;
  logic             in_valid = 1'b0;
  logic [N*A_W-1:0] a_vec = '0;
  logic [N*B_W-1:0] b_vec = '0;
  logic [N*A_W-1:0] a_edge;
  logic [N*B_W-1:0] b_edge;

  always #5 clk = ~clk;

  sa_operand_feeder #(.N(N), .A_W(A_W), .B_W(B_W), .K_MAX(K_MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
    .a_edge(a_edge), .b_edge(b_edge), .clr_out(clr_out)
  );

  // Attached 2x2 output-stationary PE array: operands pass east/south through registers.
  logic signed [A_W-1:0] pa_q  [N][N];
  logic signed [B_W-1:0] pb_q  [N][N];
  logic signed [A_W-1:0] p_ain [N][N];
  logic signed [B_W-1:0] p_bin [N][N];
  logic signed [31:0]    acc   [N][N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        p_ain[i][j] = '0;
        p_bin[i][j] = '0;
        if (j == 0) p_ain[i][j] = a_edge[i*A_W +: A_W];
        else        p_ain[i][j] = pa_q[i][j-1];
        if (i == 0) p_bin[i][j] = b_edge[j*B_W +: B_W];
        else        p_bin[i][j] = pb_q[i-1][j];
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!rst) begin
          pa_q[i][j] <= '0;
          pb_q[i][j] <= '0;
          acc[i][j]  <= '0;
        end else begin
          pa_q[i][j] <= p_ain[i][j];
          pb_q[i][j] <= p_bin[i][j];
          acc[i][j]  <= clr_out ? 32'sd0 : acc[i][j] + p_ain[i][j] * p_bin[i][j];
        end
      end
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    int c00; int c01; int c10; int c11;
    int lat;
    bit from_start;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_exp(input int c00, input int c01, input int c10, input int c11,
                          input int lat, input bit from_start);
    exp_t e;
    e.c00 = c00; e.c01 = c01; e.c10 = c10; e.c11 = c11;
    e.lat = lat; e.from_start = from_start;
    exp_q.push_back(e);
  endtask

  int cyc = 0;
  int last_acc = 0;
  int start_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rst && in_valid && in_ready) last_acc = cyc;
    if (rst && start && !busy) start_cyc = cyc;
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("c00", acc[0][0], e.c00);
        chk("c01", acc[0][1], e.c01);
        chk("c10", acc[1][0], e.c10);
        chk("c11", acc[1][1], e.c11);
        chk("done_latency", e.from_start ? cyc - start_cyc : cyc - last_acc, e.lat);
      end
    end
  end

  task automatic start_job(input int k);
    start = 1'b1;
    k_len = KW'(k);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] a0, input logic [7:0] a1,
                      input logic [7:0] b0, input logic [7:0] b1);
    int n = 0;
    in_valid = 1'b1;
    a_vec = {a1, a0};
    b_vec = {b1, b0};
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("beat_accept_timeout", 0, 1);
    else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("idle_timeout", 0, 1);
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int clr_cnt;
    int rdy_cnt;
    int n;

    rst = 1'b0; start = 1'b1; in_valid = 1'b1;
    a_vec = 16'h7f7f; b_vec = 16'h8181; k_len = 9'd5;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_edge", a_edge, 0);
    chk("rst_b_edge", b_edge, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_clr_out", clr_out, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; a_vec = '0; b_vec = '0; k_len = '0;
    @(posedge clk); #1;

    // back-to-back beats, with edge-skew timing
    push_exp(19, 22, 43, 50, 4, 1'b0);
    start_job(2);
    beat(8'd1, 8'd3, 8'd5, 8'd6);
    chk("t1_a_row0", a_edge[7:0], 1);
    chk("t1_a_row1", a_edge[15:8], 0);
    chk("t1_b_col0", b_edge[7:0], 5);
    chk("t1_b_col1", b_edge[15:8], 0);
    beat(8'd2, 8'd4, 8'd7, 8'd8);
    chk("t2_a_row0", a_edge[7:0], 2);
    chk("t2_a_row1", a_edge[15:8], 3);
    chk("t2_b_col0", b_edge[7:0], 7);
    chk("t2_b_col1", b_edge[15:8], 6);
    @(posedge clk); #1;
    chk("t3_a_row0", a_edge[7:0], 0);
    chk("t3_a_row1", a_edge[15:8], 4);
    chk("t3_b_col1", b_edge[15:8], 8);
    wait_idle();

    // bubbles between beats
    push_exp(19, 22, 43, 50, 4, 1'b0);
    start_job(2);
    beat(8'd1, 8'd3, 8'd5, 8'd6);
    for (int i = 0; i < 3; i++) begin
      chk("gap_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    beat(8'd2, 8'd4, 8'd7, 8'd8);
    wait_idle();

    // signed extremes, then all ones proving the clear
    push_exp(65536, 65536, 65536, 65536, 4, 1'b0);
    start_job(4);
    for (int i = 0; i < 4; i++) beat(8'h80, 8'h80, 8'h80, 8'h80);
    wait_idle();
    push_exp(4, 4, 4, 4, 4, 1'b0);
    start_job(4);
    for (int i = 0; i < 4; i++) beat(8'd1, 8'd1, 8'd1, 8'd1);
    wait_idle();

    // empty job
    push_exp(0, 0, 0, 0, 3, 1'b1);
    start_job(0);
    clr_cnt = 0; rdy_cnt = 0; n = 0;
    do begin
      if (clr_out) clr_cnt++;
      if (in_ready) rdy_cnt++;
      @(posedge clk); #1;
      n++;
    end while (busy && n < 20);
    chk("k0_clr_cycles", clr_cnt, 1);
    chk("k0_ready_cycles", rdy_cnt, 0);
    wait_idle();

    // start pulsed mid-stream is ignored
    push_exp(19, 22, 43, 50, 4, 1'b0);
    start_job(2);
    beat(8'd1, 8'd3, 8'd5, 8'd6);
    start = 1'b1; k_len = 9'd1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("midstart_busy", busy, 1);
    chk("midstart_in_ready", in_ready, 1);
    beat(8'd2, 8'd4, 8'd7, 8'd8);
    wait_idle();

    // reset mid-stream, then a clean job
    start_job(2);
    beat(8'd1, 8'd3, 8'd5, 8'd6);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_a_edge", a_edge, 0);
    chk("midrst_b_edge", b_edge, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_clr_out", clr_out, 0);
    chk("midrst_in_ready", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    push_exp(19, 22, 43, 50, 4, 1'b0);
    start_job(2);
    beat(8'd1, 8'd3, 8'd5, 8'd6);
    beat(8'd2, 8'd4, 8'd7, 8'd8);
    wait_idle();

    chk("pending_done", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
